// File: rtl/pilha_ula.sv
// Stack-based arithmetic unit: LOAD/POP/ADD/SUB/CLR in one cycle, MUL as a WIDTH-cycle
// shift-add sequence. Faults set a sticky error flag and never touch stack contents.
module pilha_ula #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       tx,
    input  logic [4:0]       entrada,
    output logic [WIDTH-1:0] topo,
    output logic [3:0]       profundidade,
    output logic             vazia,
    output logic             cheia,
    output logic             ocupado,
    output logic             erro
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [4:0] CmdLoad = 5'd1;
    localparam logic [4:0] CmdAdd  = 5'd2;
    localparam logic [4:0] CmdSub  = 5'd3;
    localparam logic [4:0] CmdMul  = 5'd4;
    localparam logic [4:0] CmdPop  = 5'd5;
    localparam logic [4:0] CmdClr  = 5'd6;

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state;
    logic [WIDTH-1:0] pilha [DEPTH];
    logic [3:0]       prof;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mul_a, mul_b, acc;

    logic [3:0]       prof_m1;
    logic [AW-1:0]    idx_t, idx_n, idx_p;
    logic [WIDTH-1:0] val_t, val_n, acc_nxt;
    logic             menos_de_dois;

    assign prof_m1       = prof - 4'd1;
    assign idx_t         = prof_m1[AW-1:0];
    assign idx_n         = idx_t - AW'(1);
    assign idx_p         = prof[AW-1:0];
    assign val_t         = pilha[idx_t];
    assign val_n         = pilha[idx_n];
    assign menos_de_dois = (prof < 4'd2);
    assign acc_nxt       = acc + (mul_b[0] ? mul_a : '0);

    assign topo         = (prof == 4'd0) ? '0 : val_t;
    assign profundidade = prof;
    assign vazia        = (prof == 4'd0);
    assign cheia        = (prof == 4'(DEPTH));
    assign ocupado      = (state == StRun);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            prof  <= '0;
            erro  <= 1'b0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            for (int i = 0; i < DEPTH; i++) pilha[i] <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    case (tx)
                        CmdLoad: begin
                            if (cheia) erro <= 1'b1;
                            else begin
                                pilha[idx_p] <= WIDTH'(entrada);
                                prof         <= prof + 4'd1;
                            end
                        end
                        CmdAdd, CmdSub: begin
                            if (menos_de_dois) erro <= 1'b1;
                            else begin
                                pilha[idx_n] <= (tx == CmdAdd) ? val_n + val_t : val_n - val_t;
                                prof         <= prof_m1;
                            end
                        end
                        CmdMul: begin
                            if (menos_de_dois) erro <= 1'b1;
                            else begin
                                mul_a <= val_n;
                                mul_b <= val_t;
                                acc   <= '0;
                                cnt   <= CW'(WIDTH);
                                state <= StRun;
                            end
                        end
                        CmdPop: begin
                            if (vazia) erro <= 1'b1;
                            else prof <= prof_m1;
                        end
                        CmdClr: begin
                            prof <= '0;
                            erro <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                StRun: begin
                    // One shift-add step per cycle; the last step writes the product over N.
                    acc   <= acc_nxt;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        pilha[idx_n] <= acc_nxt;
                        prof         <= prof_m1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
